// File: rtl/traffic_phase_scheduler_if.sv
// Request/lamp bundle between the intersection controller and its environment.
// The master side drives the timebase and requests; the slave side is the scheduler.
interface traffic_phase_scheduler_if;
    logic       tick;
    logic       side_req;
    logic       ped_req;
    logic [5:0] lights;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output tick,
        output side_req,
        output ped_req,
        input  lights,
        input  walk,
        input  phase
    );

    modport slave (
        input  tick,
        input  side_req,
        input  ped_req,
        output lights,
        output walk,
        output phase
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler: main road rests green, side road and pedestrians
// are served on request with min/max green and all-red clearance; Moore outputs.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned PED_T     = 10,
    parameter int unsigned CW        = 5
) (
    input logic                      clk,
    input logic                      clr,
    traffic_phase_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        StMainG   = 3'd0,
        StMainY   = 3'd1,
        StAr1     = 3'd2,
        StSideG   = 3'd3,
        StSideY   = 3'd4,
        StAr2     = 3'd5,
        StPedWalk = 3'd6
    } state_e;

    // Terminal counts: a phase of N ticks leaves on the tick where cnt == N-1.
    localparam logic [CW-1:0] GreenMinEnd = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GreenMaxEnd = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YellowEnd   = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AllRedEnd   = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] PedEnd      = CW'(PED_T - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          side_pend_q, side_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic [5:0]    lights_q, lights_d;
    logic          walk_q, walk_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StMainG;
            cnt_q       <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            lights_q    <= 6'b001100;
            walk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            lights_q    <= lights_d;
            walk_q      <= walk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StMainG: begin
                if (bus.tick && cnt_q >= GreenMinEnd && (side_pend_q || ped_pend_q)) begin
                    state_d = StMainY;
                end
            end
            StMainY: begin
                if (bus.tick && cnt_q == YellowEnd) state_d = StAr1;
            end
            StAr1: begin
                if (bus.tick && cnt_q == AllRedEnd) begin
                    if (ped_pend_q)       state_d = StPedWalk;
                    else if (side_pend_q) state_d = StSideG;
                    else                  state_d = StMainG;
                end
            end
            StPedWalk: begin
                if (bus.tick && cnt_q == PedEnd) begin
                    state_d = side_pend_q ? StSideG : StMainG;
                end
            end
            StSideG: begin
                // Early exit looks at the live sensor, not the latch.
                if (bus.tick && (cnt_q == GreenMaxEnd ||
                                 (cnt_q >= GreenMinEnd && !bus.side_req))) begin
                    state_d = StSideY;
                end
            end
            StSideY: begin
                if (bus.tick && cnt_q == YellowEnd) state_d = StAr2;
            end
            StAr2: begin
                if (bus.tick && cnt_q == AllRedEnd) state_d = StMainG;
            end
            default: state_d = StMainG;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (bus.tick && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        side_pend_d = side_pend_q | (bus.side_req & (state_q != StSideG));
        if (state_d == StSideG && state_q != StSideG) side_pend_d = 1'b0;

        ped_pend_d = ped_pend_q | (bus.ped_req & (state_q != StPedWalk));
        if (state_d == StPedWalk && state_q != StPedWalk) ped_pend_d = 1'b0;
    end

    // Lamps are decoded from the next state so they register on the same edge.
    always_comb begin
        lights_d = 6'b001100;
        walk_d   = 1'b0;
        case (state_d)
            StMainG:   lights_d = 6'b001100;
            StMainY:   lights_d = 6'b010100;
            StAr1:     lights_d = 6'b100100;
            StSideG:   lights_d = 6'b100001;
            StSideY:   lights_d = 6'b100010;
            StAr2:     lights_d = 6'b100100;
            StPedWalk: begin
                lights_d = 6'b100100;
                walk_d   = 1'b1;
            end
            default:   lights_d = 6'b001100;
        endcase
    end

    assign bus.lights = lights_q;
    assign bus.walk   = walk_q;
    assign bus.phase  = state_q;

endmodule
